// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : MIPS32 hazard unit: ID operand forwarding, load-use stall, MDU
//            multi-cycle stall sequencing and branch flush gating.
//            Optional stall statistics counter enabled by HAZARD_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RPORTS = 2,
    parameter int MDU_LAT    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RPORTS*ADDR_W-1:0] raddr,
    input  logic [NUM_RPORTS-1:0]        rused,
    input  logic [NUM_RPORTS*DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0]            ex_result,
    input  logic [ADDR_W-1:0]            ex_waddr,
    input  logic                         ex_reg_wr,
    input  logic                         ex_load,
    input  logic [DATA_W-1:0]            mem_result,
    input  logic [ADDR_W-1:0]            mem_waddr,
    input  logic                         mem_reg_wr,
    input  logic [DATA_W-1:0]            wb_result,
    input  logic [ADDR_W-1:0]            wb_waddr,
    input  logic                         wb_reg_wr,
    input  logic                         mdu_start,
    input  logic                         branch_taken,
    output logic [NUM_RPORTS*DATA_W-1:0] fwd_rdata,
    output logic                         stall_if,
    output logic                         stall_id,
    output logic                         flush_id,
    output logic                         flush_ex,
    output logic                         mdu_busy,
    output logic                         mdu_done,
    output logic [31:0]                  stall_cnt
);

    localparam int              CNT_W    = $clog2(MDU_LAT);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(MDU_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_mdu_done;
    logic             w_done_nxt;
    logic             w_load_match;
    logic             w_load_hz;
    logic             w_stall;

    // Forwarding: youngest producer wins; $0 is never forwarded.
    generate
        for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_fwd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = raddr[gi*ADDR_W +: ADDR_W];
            always_comb begin
                fwd_rdata[gi*DATA_W +: DATA_W] = rdata[gi*DATA_W +: DATA_W];
                if (w_addr != '0) begin
                    if (ex_reg_wr && ex_waddr == w_addr)
                        fwd_rdata[gi*DATA_W +: DATA_W] = ex_result;
                    else if (mem_reg_wr && mem_waddr == w_addr)
                        fwd_rdata[gi*DATA_W +: DATA_W] = mem_result;
                    else if (wb_reg_wr && wb_waddr == w_addr)
                        fwd_rdata[gi*DATA_W +: DATA_W] = wb_result;
                end
            end
        end
    endgenerate

    always_comb begin
        w_load_match = 1'b0;
        for (int i = 0; i < NUM_RPORTS; i++) begin
            if (rused[i] && raddr[i*ADDR_W +: ADDR_W] == ex_waddr)
                w_load_match = 1'b1;
        end
    end

    assign w_load_hz = ex_load & ex_reg_wr & (ex_waddr != '0) & w_load_match;

    // Reset forces the pipeline clear and suppresses every stall.
    assign w_stall  = ~rst & (w_load_hz | (r_state == ST_BUSY));
    assign stall_if = w_stall;
    assign stall_id = w_stall;
    assign flush_ex = rst | w_stall;
    assign flush_id = rst | (branch_taken & ~w_stall);
    assign mdu_busy = (r_state == ST_BUSY);
    assign mdu_done = r_mdu_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mdu_start && !w_load_hz) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = C_CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mdu_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mdu_done <= w_done_nxt;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed plus randomized bench for hazard_ctrl with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NP  = 2;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*AW-1:0] raddr;
    logic [NP-1:0]    rused;
    logic [NP*DW-1:0] rdata;
    logic [DW-1:0]    ex_result, mem_result, wb_result;
    logic [AW-1:0]    ex_waddr, mem_waddr, wb_waddr;
    logic             ex_reg_wr, ex_load, mem_reg_wr, wb_reg_wr;
    logic             mdu_start, branch_taken;
    logic [NP*DW-1:0] fwd_rdata;
    logic             stall_if, stall_id, flush_id, flush_ex;
    logic             mdu_busy, mdu_done;
    logic [31:0]      stall_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_left   = 0;
    logic        m_done   = 1'b0;
    int unsigned m_cnt    = 0;

    hazard_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_RPORTS(NP), .MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rused(rused), .rdata(rdata),
        .ex_result(ex_result), .ex_waddr(ex_waddr), .ex_reg_wr(ex_reg_wr),
        .ex_load(ex_load), .mem_result(mem_result), .mem_waddr(mem_waddr),
        .mem_reg_wr(mem_reg_wr), .wb_result(wb_result), .wb_waddr(wb_waddr),
        .wb_reg_wr(wb_reg_wr), .mdu_start(mdu_start), .branch_taken(branch_taken),
        .fwd_rdata(fwd_rdata), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_fwd(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (a == 0) return rdata[i*DW +: DW];
        if (ex_reg_wr && ex_waddr == a) return ex_result;
        if (mem_reg_wr && mem_waddr == a) return mem_result;
        if (wb_reg_wr && wb_waddr == a) return wb_result;
        return rdata[i*DW +: DW];
    endfunction

    function automatic logic model_load_hz();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NP; i++)
            if (rused[i] && raddr[i*AW +: AW] == ex_waddr) hit = 1'b1;
        return hit && ex_load && ex_reg_wr && ex_waddr != 0;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic lhz, stl;
        @(negedge clk);
        lhz = model_load_hz();
        stl = !rst && (lhz || m_left > 0);
        if (!lhz)
            for (int i = 0; i < NP; i++)
                chk($sformatf("fwd%0d", i), 64'(fwd_rdata[i*DW +: DW]), 64'(model_fwd(i)));
        chk("stall_if", 64'(stall_if), 64'(stl));
        chk("stall_id", 64'(stall_id), 64'(stl));
        chk("flush_ex", 64'(flush_ex), 64'(rst || stl));
        chk("flush_id", 64'(flush_id), 64'(rst || (branch_taken && !stl)));
        chk("mdu_busy", 64'(mdu_busy), 64'(m_left > 0));
        chk("mdu_done", 64'(mdu_done), 64'(m_done));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_cnt = 0;
        end else begin
`ifdef HAZARD_STAT_EN
            if (stl) m_cnt = m_cnt + 1;
`endif
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end else begin
                m_done = 1'b0;
                if (mdu_start && !lhz) m_left = LAT;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; raddr = '0; rused = '0; rdata = '0;
        ex_result = '0; mem_result = '0; wb_result = '0;
        ex_waddr = '0; mem_waddr = '0; wb_waddr = '0;
        ex_reg_wr = 1'b0; ex_load = 1'b0; mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
        mdu_start = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Forwarding priority chain
        raddr = {5'd0, 5'd3}; rdata = {32'h2222, 32'h1111};
        ex_waddr = 5'd3; ex_reg_wr = 1'b1; ex_result = 32'hAAAA;
        mem_waddr = 5'd3; mem_reg_wr = 1'b1; mem_result = 32'hBBBB;
        wb_waddr = 5'd3; wb_reg_wr = 1'b1; wb_result = 32'hCCCC;
        #1 chk("fwd_ex", 64'(fwd_rdata[31:0]), 64'h AAAA);
        step();
        ex_reg_wr = 1'b0;
        #1 chk("fwd_mem", 64'(fwd_rdata[31:0]), 64'hBBBB);
        step();
        mem_reg_wr = 1'b0;
        #1 chk("fwd_wb", 64'(fwd_rdata[31:0]), 64'hCCCC);
        step();
        raddr = '0; ex_waddr = '0; mem_waddr = '0; wb_waddr = '0;
        ex_reg_wr = 1'b1; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
        #1 chk("fwd_r0", 64'(fwd_rdata[31:0]), 64'h1111);
        step();
        idle_inputs();

        // Load-use: one stall cycle, then the load has moved on
        raddr = {5'd5, 5'd0}; rused = 2'b10;
        ex_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd5; branch_taken = 1'b1;
        #1 chk("load_stall", 64'(stall_if), 64'd1);
        chk("br_in_stall", 64'(flush_id), 64'd0);
        step();
        ex_load = 1'b0;
        #1 chk("br_after", 64'(flush_id), 64'd1);
        step();
        ex_load = 1'b1; rused = 2'b00; branch_taken = 1'b0;
        #1 chk("load_unused", 64'(stall_if), 64'd0);
        step();
        idle_inputs();

        // MDU op, with a re-issue mid-BUSY that must not extend it
        mdu_start = 1'b1; step();
        mdu_start = 1'b0; step();
        mdu_start = 1'b1; step();
        mdu_start = 1'b0;
        repeat (4) step();

        // Reset mid-BUSY aborts without a done pulse
        mdu_start = 1'b1; step();
        mdu_start = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        step();

        // Stall statistics: one load stall plus one MDU op
        rst = 1'b1; step();
        rst = 1'b0;
        raddr = {5'd0, 5'd7}; rused = 2'b01;
        ex_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd7; step();
        idle_inputs();
        mdu_start = 1'b1; step();
        mdu_start = 1'b0;
        repeat (6) step();
`ifdef HAZARD_STAT_EN
        chk("stat_total", 64'(stall_cnt), 64'd5);
`else
        chk("stat_total", 64'(stall_cnt), 64'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(199) == 0);
            raddr        = NP*AW'($urandom_range(1023) & 10'h0E7);
            rused        = NP'($urandom);
            rdata        = {$urandom, $urandom};
            ex_result    = $urandom; mem_result = $urandom; wb_result = $urandom;
            ex_waddr     = AW'($urandom_range(7));
            mem_waddr    = AW'($urandom_range(7));
            wb_waddr     = AW'($urandom_range(7));
            ex_reg_wr    = 1'($urandom);
            mem_reg_wr   = 1'($urandom);
            wb_reg_wr    = 1'($urandom);
            ex_load      = ($urandom_range(3) == 0);
            mdu_start    = ($urandom_range(5) == 0);
            branch_taken = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Next-generation hazard unit for the 5-stage MIPS32 pipeline.
- Forwards register operands into ID from EX, MEM and WB for a parametrised number of read ports.
- Detects load-use hazards and stalls/bubbles for them.
- Sequences multi-cycle MDU (mult/div) stalls with an internal counter FSM, and gates ID flush on taken branches.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_RPORTS, 2, number of ID read ports forwarded
MDU_LAT, 32, MDU busy cycles per operation (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
raddr  in  NUM_RPORTS*ADDR_W  ID read addresses, port i at [i*ADDR_W +: ADDR_W]
rused  in  NUM_RPORTS  port i operand actually consumed by ID instruction
rdata  in  NUM_RPORTS*DATA_W  regfile read data
ex_result  in  DATA_W  EX ALU result
ex_waddr  in  ADDR_W  EX destination
ex_reg_wr  in  1  EX writes register
ex_load  in  1  EX instruction is a load (result not yet valid)
mem_result  in  DATA_W  MEM result (load data or ALU result)
mem_waddr  in  ADDR_W  MEM destination
mem_reg_wr  in  1  MEM writes register
wb_result  in  DATA_W  WB write data
wb_waddr  in  ADDR_W  WB destination
wb_reg_wr  in  1  WB writes register
mdu_start  in  1  ID issues an MDU op this cycle
branch_taken  in  1  ID branch resolved taken
fwd_rdata  out  NUM_RPORTS*DATA_W  forwarded operands
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  clear IF/ID register
flush_ex  out  1  insert bubble into ID/EX
mdu_busy  out  1  MDU FSM in BUSY (registered)
mdu_done  out  1  one-cycle pulse on BUSY->IDLE (registered)
stall_cnt  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Forwarding (combinational, per port): EX > MEM > WB > rdata. A stage matches when its reg_wr=1, its waddr==raddr[i] and raddr[i]!=0. raddr[i]==0 always returns rdata[i].
- load_hz = ex_load & ex_reg_wr & ex_waddr!=0 & any i (rused[i] & raddr[i]==ex_waddr). fwd_rdata during load_hz is don't-care.
- mdu_hz = (state==BUSY).
- stall = load_hz | mdu_hz. stall_if = stall_id = stall. flush_ex = stall.
- flush_id = branch_taken & ~stall. The branch re-resolves after the stall clears.
- MDU FSM, IDLE/BUSY, counter width clog2(MDU_LAT):
  - IDLE & mdu_start & ~load_hz: go to BUSY, cnt <= MDU_LAT-1. The issuing cycle itself is not stalled.
  - BUSY: cnt decrements each cycle. When cnt==0, go to IDLE and mdu_done <= 1 for one cycle.
  - mdu_start while BUSY or during load_hz is ignored (ID is held, so it is re-presented).
- Reset (synchronous):
  - state=IDLE, cnt=0, mdu_busy=0, mdu_done=0, stall_cnt=0.
  - While rst=1: stall_if=stall_id=0, flush_id=flush_ex=1.
  - Reset mid-BUSY aborts the operation with no mdu_done pulse.
- Simultaneous load_hz and BUSY: single stall, no double count.

Optional Feature:
- Macro HAZARD_STAT_EN.
- Defined: stall_cnt is a 32-bit register that increments every cycle with stall=1 and rst=0, wraps 0xFFFFFFFF->0, and clears on reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- raddr0=3, ex_waddr=3 ex_reg_wr=1 ex_result=0xAAAA, mem_waddr=3 mem_result=0xBBBB -> fwd port0=0xAAAA; drop ex_reg_wr -> 0xBBBB; drop mem -> wb_result; raddr=0 with all stages writing $0 -> rdata.
- ex_load=1 ex_waddr=5, raddr1=5 rused=2'b10 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle. Same with rused=2'b00 -> no stall.
- mdu_start pulse with MDU_LAT=4 -> mdu_busy/stall high for 4 cycles after the issue cycle, then mdu_done=1 for 1 cycle. mdu_start repeated mid-BUSY -> no extension.
- branch_taken=1 during load_hz -> flush_id=0; next cycle (no stall) branch_taken=1 -> flush_id=1.
- rst asserted at cnt=2 in BUSY -> next cycle mdu_busy=0, mdu_done stays 0, stall=0.
- HAZARD_STAT_EN defined: one load stall plus one MDU op with MDU_LAT=4 -> stall_cnt=5. Undefined -> stall_cnt=0.
